// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding and counter width for the TLC request front end.
package tlc_pkg;
    localparam int TLC_CNT_W = 16;
    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, ISSUE = 2'b10} tlc_req_state_t;
endpackage

// File: rtl/tlc_debounce.sv
// tlc_debounce: two-flop synchroniser plus counter debouncer with a rising-edge pulse.
module tlc_debounce
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn,
    output logic btn_db,
    output logic rise
);
    localparam logic [TLC_CNT_W-1:0] LAST = TLC_CNT_W'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, db_q;
    logic [TLC_CNT_W-1:0] cnt;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_q   <= 1'b0;
            btn_db <= 1'b0;
            cnt    <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= btn_db;
            if (s2 == btn_db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt    <= '0;
                btn_db <= ~btn_db;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign rise = btn_db & ~db_q;
endmodule

// File: rtl/tlc_go_requester.sv
// tlc_go_requester: debounced button request latch driving GO under a READY/GO handshake.
// Optional idle auto-request enabled by defining TLC_AUTO_GO_EN.
module tlc_go_requester
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_GO_CYCLES  = 1024
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    input  logic READY,
    output logic GO,
    output logic REQ_PENDING,
    output logic REQ_ACK,
    output logic BTN_DB
);
    tlc_req_state_t state, nxt;
    logic rise, arm, again;
    tlc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .CLK(CLK),
        .RST_N(RST_N),
        .btn(BTN),
        .btn_db(BTN_DB),
        .rise(rise)
    );
`ifdef TLC_AUTO_GO_EN
    logic [TLC_CNT_W-1:0] auto_cnt;
    logic auto_fire;
    assign auto_fire = (state == IDLE) && READY && (auto_cnt == TLC_CNT_W'(AUTO_GO_CYCLES - 1));
    assign arm = rise | auto_fire;
    // Counting only while staying in IDLE clears the count on firing, on a press and on READY=0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) auto_cnt <= '0;
        else        auto_cnt <= (nxt == IDLE && READY) ? auto_cnt + 1'b1 : '0;
    end
`else
    assign arm = rise;
`endif
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = arm ? ARMED : IDLE;
            ARMED:   nxt = READY ? ISSUE : ARMED;
            ISSUE:   nxt = READY ? ISSUE : ((again || rise) ? ARMED : IDLE);
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            GO      <= 1'b0;
            REQ_ACK <= 1'b0;
            again   <= 1'b0;
        end else begin
            state   <= nxt;
            GO      <= (nxt == ISSUE);
            REQ_ACK <= (state == ISSUE) && (nxt != ISSUE);
            again   <= (state == ISSUE) && (nxt == ISSUE) && (again || rise);
        end
    end
    assign REQ_PENDING = (state != IDLE);
endmodule

// File: tb/tb_tlc_go_requester.sv
// tb_tlc_go_requester: directed and randomized checks against a cycle-level reference model.
module tb_tlc_go_requester;
    localparam int DEB  = 16;
    localparam int AUTO = 8;
    logic CLK = 1'b0, RST_N = 1'b0, BTN = 1'b0, READY = 1'b0;
    logic GO, REQ_PENDING, REQ_ACK, BTN_DB;
    int checks = 0, failures = 0;
    bit hist[$];
    bit m_db, m_rise, m_armed, m_iss, m_again, m_ack;
    int m_auto;
    int btn_left = 0, rdy_left = 0;

    tlc_go_requester #(.DEBOUNCE_CYCLES(DEB), .AUTO_GO_CYCLES(AUTO)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BTN(BTN),
        .READY(READY),
        .GO(GO),
        .REQ_PENDING(REQ_PENDING),
        .REQ_ACK(REQ_ACK),
        .BTN_DB(BTN_DB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        hist.delete();
        repeat (DEB + 2) hist.push_back(1'b0);
        {m_db, m_rise, m_armed, m_iss, m_again, m_ack} = '0;
        m_auto = 0;
    endfunction

    // hist[k] is the BTN level sampled k edges ago; the debounced level flips once
    // the synchronised samples (2 edges late) have disagreed with it DEB times in a row.
    function automatic void m_step();
        bit flip, press;
        hist.push_front(BTN);
        void'(hist.pop_back());
        flip = 1'b1;
        for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_db) flip = 1'b0;
        press  = m_rise;
        m_rise = flip && !m_db;
        if (flip) m_db = !m_db;
        m_ack = 1'b0;
        if (m_iss) begin
            if (press) m_again = 1'b1;
            if (!READY) begin
                m_iss   = 1'b0;
                m_armed = m_again;
                m_again = 1'b0;
                m_ack   = 1'b1;
            end
        end else if (m_armed) begin
            if (READY) begin
                m_armed = 1'b0;
                m_iss   = 1'b1;
            end
        end else if (press) begin
            m_armed = 1'b1;
            m_auto  = 0;
        end else begin
`ifdef TLC_AUTO_GO_EN
            m_auto = READY ? m_auto + 1 : 0;
            if (m_auto == AUTO) begin
                m_armed = 1'b1;
                m_auto  = 0;
            end
`endif
        end
        if (m_armed || m_iss) m_auto = 0;
    endfunction

    task automatic check_all();
        chk("go", GO, m_iss);
        chk("pending", REQ_PENDING, m_armed || m_iss);
        chk("ack", REQ_ACK, m_ack);
        chk("btn_db", BTN_DB, m_db);
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (!RST_N) m_reset();
        else m_step();
        @(negedge CLK);
        check_all();
    endtask

    task automatic press_release();
        BTN = 1'b1;
        repeat (DEB + 4) cyc();
        BTN = 1'b0;
        repeat (DEB + 4) cyc();
    endtask

    initial begin
        m_reset();
        BTN = 1'b1;
        repeat (3) @(negedge CLK);
        check_all();
        RST_N = 1'b1;
        for (int e = 1; e <= DEB + 4; e++) begin
            cyc();
            if (e == DEB + 1) chk("db_before", BTN_DB, 0);
            if (e == DEB + 2) begin
                chk("db_edge", BTN_DB, 1);
                chk("arm_before", REQ_PENDING, 0);
            end
            if (e == DEB + 3) chk("armed", REQ_PENDING, 1);
        end
        BTN = 1'b0;
        repeat (DEB + 4) cyc();
        READY = 1'b1;
        cyc();
        chk("go_latency", GO, 1);
        READY = 1'b0;
        cyc();
        chk("ack_pulse", REQ_ACK, 1);
        chk("go_fall", GO, 0);
        cyc();
        chk("ack_once", REQ_ACK, 0);
        chk("idle_after", REQ_PENDING, 0);

        BTN = 1'b1;
        repeat (10) cyc();
        BTN = 1'b0;
        repeat (DEB + 6) begin
            cyc();
            chk("glitch_db", BTN_DB, 0);
            chk("glitch_pend", REQ_PENDING, 0);
        end

        press_release();
        READY = 1'b1;
        cyc();
        press_release();
        press_release();
        chk("issue_hold", GO, 1);
        READY = 1'b0;
        cyc();
        chk("rearm_ack", REQ_ACK, 1);
        chk("rearm_pend", REQ_PENDING, 1);
        chk("rearm_go", GO, 0);
        READY = 1'b1;
        cyc();
        chk("regoo", GO, 1);
        READY = 1'b0;
        cyc();
        chk("single_rearm", REQ_PENDING, 0);

        BTN = 1'b1;
        repeat (DEB + 4) cyc();
        BTN = 1'b0;
        READY = 1'b1;
        repeat (3) cyc();
        chk("pre_rst_go", GO, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_async_go", GO, 0);
        chk("rst_async_pend", REQ_PENDING, 0);
        m_reset();
        READY = 1'b0;
        repeat (3) cyc();
        RST_N = 1'b1;
        repeat (30) cyc();
        chk("idle_after_rst", REQ_PENDING, 0);

`ifdef TLC_AUTO_GO_EN
        READY = 1'b1;
        repeat (AUTO - 1) cyc();
        chk("auto_before", REQ_PENDING, 0);
        cyc();
        chk("auto_armed", REQ_PENDING, 1);
        cyc();
        chk("auto_go", GO, 1);
        READY = 1'b0;
        repeat (3) cyc();
`endif

        repeat (3000) begin
            if (btn_left == 0) begin
                BTN = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 40);
            end
            if (rdy_left == 0) begin
                READY = 1'($urandom_range(0, 1));
                rdy_left = $urandom_range(1, 30);
            end
            btn_left--;
            rdy_left--;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
